// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with multi-word lines.
// Hits complete in the request cycle; misses run a write-back/refill word transfer FSM.
module dcache_wb_dm #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_LINES  = 128,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic [DATA_WIDTH/8-1:0] cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ready,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    busy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned WB  = $clog2(LINE_WORDS);
  localparam int unsigned IB  = $clog2(NUM_LINES);
  localparam int unsigned TAG = ADDR_WIDTH - IB - WB - OFF;
  localparam int unsigned WBW = (WB > 0) ? WB : 1;
  localparam int unsigned IBW = (IB > 0) ? IB : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_e;

  state_e                state_q, state_d;
  logic [WBW-1:0]        cnt_q, cnt_d;
  logic [IBW-1:0]        idx_q, idx_d;
  logic [TAG-1:0]        ntag_q, ntag_d;
  logic                  flush_done_q, flush_done_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;

  logic [TAG-1:0]        tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];

  logic [TAG-1:0]        req_tag;
  logic [IBW-1:0]        req_idx;
  logic [WBW-1:0]        req_word;
  logic                  req_hit;
  logic                  last_word;
  logic                  last_line;

  logic                  wr_en;
  logic [IBW-1:0]        wr_idx;
  logic [WBW-1:0]        wr_word;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  tag_we;

  assign req_tag   = cpu_addr[ADDR_WIDTH-1 -: TAG];
  assign req_idx   = IBW'(cpu_addr >> (OFF + WB));
  assign req_word  = (WB == 0) ? '0 : WBW'(cpu_addr >> OFF);
  assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_word = (cnt_q == WBW'(LINE_WORDS - 1));
  assign last_line = (idx_q == IBW'(NUM_LINES - 1));

  assign busy       = (state_q != S_IDLE);
  assign flush_done = flush_done_q;

  // Word-aligned bus address of word w in line i carrying tag t.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG-1:0] t,
                                                      input logic [IBW-1:0] i,
                                                      input logic [WBW-1:0] w);
    line_addr = (ADDR_WIDTH'(t) << (IB + WB + OFF)) |
                (ADDR_WIDTH'(i) << (WB + OFF)) |
                ((WB == 0) ? '0 : (ADDR_WIDTH'(w) << OFF));
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    ntag_d       = ntag_q;
    flush_done_d = 1'b0;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    wr_en        = 1'b0;
    wr_idx       = idx_q;
    wr_word      = cnt_q;
    wr_be        = '1;
    wr_data      = mem_rdata;
    tag_we       = 1'b0;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          idx_d   = '0;
          state_d = S_FLUSH_SCAN;
        end else if (cpu_req) begin
          if (req_hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_q[req_idx][req_word];
            if (|cpu_we) begin
              wr_en            = 1'b1;
              wr_idx           = req_idx;
              wr_word          = req_word;
              wr_be            = cpu_we;
              wr_data          = cpu_wdata;
              dirty_d[req_idx] = 1'b1;
            end
          end else begin
            // The miss target is latched so the transfer does not depend on cpu_* later.
            cnt_d   = '0;
            idx_d   = req_idx;
            ntag_d  = req_tag;
            state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_REFILL;
          end
        end
      end

      S_WRITEBACK, S_FLUSH_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(tag_q[idx_q], idx_q, cnt_q);
        mem_wdata = data_q[idx_q][cnt_q];
        if (mem_ack) begin
          cnt_d = cnt_q + WBW'(1);
          if (last_word) begin
            cnt_d          = '0;
            dirty_d[idx_q] = 1'b0;
            if (state_q == S_WRITEBACK) begin
              state_d = S_REFILL;
            end else begin
              valid_d[idx_q] = 1'b0;
              if (last_line) begin
                flush_done_d = 1'b1;
                state_d      = S_IDLE;
              end else begin
                idx_d   = idx_q + IBW'(1);
                state_d = S_FLUSH_SCAN;
              end
            end
          end
        end
      end

      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(ntag_q, idx_q, cnt_q);
        if (mem_ack) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + WBW'(1);
          if (last_word) begin
            cnt_d          = '0;
            valid_d[idx_q] = 1'b1;
            dirty_d[idx_q] = 1'b0;
            tag_we         = 1'b1;
            state_d        = S_IDLE;
          end
        end
      end

      S_FLUSH_SCAN: begin
        if (dirty_q[idx_q]) begin
          cnt_d   = '0;
          state_d = S_FLUSH_WB;
        end else begin
          valid_d[idx_q] = 1'b0;
          if (last_line) begin
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            idx_d = idx_q + IBW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      ntag_q       <= '0;
      flush_done_q <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ntag_q       <= ntag_d;
      flush_done_q <= flush_done_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q qualifies their contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) data_q[wr_idx][wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (!rst && tag_we) tag_q[idx_q] <= ntag_q;
  end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Bench for dcache_wb_dm: directed vector table, hand-written corner sequences,
// and a randomized run checked against a flat-memory plus tag-directory model.
module tb_dcache_wb_dm;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_req;
  logic [DW/8-1:0] cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_ready;
  logic            flush;
  logic            flush_done;
  logic            busy;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  always #5 clk = ~clk;

  dcache_wb_dm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LINES(NL), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] ref_m [logic [31:0]];
  xfer_t       wr_q[$];
  xfer_t       rd_q[$];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          stab_err = 0;
  bit          stray    = 1'b0;
  bit          p_wait;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_we;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h0001_9E37) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_m.exists(a)) return ref_m[a];
    return mem_rd(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks on the falling edge, optional wait states and stray acks.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    p_wait    = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst) begin
        p_wait   = 1'b0;
        wait_cnt = wait_cfg;
      end else if (mem_req) begin
        if (p_wait && (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata)))
          stab_err++;
        if (wait_cnt > 0) begin
          wait_cnt--;
          p_wait  = 1'b1;
          p_addr  = mem_addr;
          p_we    = mem_we;
          p_wdata = mem_wdata;
        end else begin
          mem_ack  = 1'b1;
          p_wait   = 1'b0;
          wait_cnt = wait_cfg;
          if (mem_we) begin
            mem_m[mem_addr] = mem_wdata;
            wr_q.push_back('{1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem_rd(mem_addr);
            rd_q.push_back('{1'b0, mem_addr, mem_rdata});
          end
        end
      end else begin
        if (p_wait) stab_err++;
        p_wait   = 1'b0;
        wait_cnt = wait_cfg;
        if (stray && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  task automatic do_reset;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = '0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One CPU access; cyc = cycles before cpu_ready (0 = same-cycle hit).
  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc, output int nwr, output int nrd);
    @(negedge clk);
    wr_q.delete();
    rd_q.delete();
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_we    = we;
    cpu_wdata = wd;
    cyc       = 0;
    rd        = 'x;
    forever begin
      #2;
      if (cpu_ready) begin
        rd = cpu_rdata;
        break;
      end
      if (cyc > 300) begin
        cyc = -1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we  = '0;
    nwr     = wr_q.size();
    nrd     = rd_q.size();
  endtask

  task automatic do_flush(output int nwr, output int ndone);
    int post;
    post  = 0;
    ndone = 0;
    @(negedge clk);
    wr_q.delete();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 3000 && post < 4; k++) begin
      #2;
      if (flush_done) ndone++;
      if (ndone > 0) post++;
      @(negedge clk);
    end
    nwr = wr_q.size();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_wr;
    int          exp_rdn;
    logic [31:0] wr_base;
    logic [31:0] rd_base;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] rd;
  int          cyc, nwr, nrd, ndone, exp_cyc;
  int          idx_set[4];
  logic        mvalid[NL];
  logic        mdirty[NL];
  logic [31:0] mtag[NL];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem_m[32'h100 + 4*i] = 32'hA0 + i;
      mem_m[32'h300 + 4*i] = 32'hC0 + i;
    end

    do_reset();
    #2;
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // Fill, partial write hit, dirty eviction, refetch of the written-back line.
    tbl[0] = '{32'h100,  4'h0, 32'h0,         1'b1, 32'hA0,        0, 4, 32'h0,   32'h100};
    tbl[1] = '{32'h104,  4'h3, 32'h1234_5678, 1'b0, 32'h0,         0, 0, 32'h0,   32'h0};
    tbl[2] = '{32'h104,  4'h0, 32'h0,         1'b1, 32'h0000_5678, 0, 0, 32'h0,   32'h0};
    tbl[3] = '{32'h10C,  4'h0, 32'h0,         1'b1, 32'hA3,        0, 0, 32'h0,   32'h0};
    tbl[4] = '{32'h2100, 4'h0, 32'h0,         1'b1, dflt(32'h2100), 4, 4, 32'h100, 32'h2100};
    tbl[5] = '{32'h104,  4'h0, 32'h0,         1'b1, 32'h0000_5678, 0, 4, 32'h0,   32'h100};
    for (int v = 0; v < 6; v++) begin
      access(tbl[v].addr, tbl[v].we, tbl[v].wdata, rd, cyc, nwr, nrd);
      exp_cyc = (tbl[v].exp_wr + tbl[v].exp_rdn == 0) ? 0 : tbl[v].exp_wr + tbl[v].exp_rdn + 1;
      if (tbl[v].chk_rd) chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rd);
      chk($sformatf("vec%0d_cycles", v), cyc, exp_cyc);
      chk($sformatf("vec%0d_wr_acks", v), nwr, tbl[v].exp_wr);
      chk($sformatf("vec%0d_rd_acks", v), nrd, tbl[v].exp_rdn);
      for (int j = 0; j < nwr; j++) chk($sformatf("vec%0d_wr_addr%0d", v, j), wr_q[j].addr, tbl[v].wr_base + 4*j);
      for (int j = 0; j < nrd; j++) chk($sformatf("vec%0d_rd_addr%0d", v, j), rd_q[j].addr, tbl[v].rd_base + 4*j);
    end
    chk("wb_mem_0x100", mem_m[32'h100], 32'hA0);
    chk("wb_mem_0x104", mem_m[32'h104], 32'h0000_5678);
    chk("wb_mem_0x108", mem_m[32'h108], 32'hA2);

    // Three wait states per word: request must hold steady, data as without waits.
    wait_cfg = 3;
    stab_err = 0;
    access(32'h300, 4'h0, 32'h0, rd, cyc, nwr, nrd);
    chk("wait_rdata", rd, 32'hC0);
    chk("wait_cycles", cyc, 17);
    chk("wait_rd_acks", nrd, 4);
    chk("wait_stable", stab_err, 0);
    wait_cfg = 0;
    access(32'h30C, 4'h0, 32'h0, rd, cyc, nwr, nrd);
    chk("wait_hit_rdata", rd, 32'hC3);

    // Dirty lines at index 0 and 127, then a full flush.
    access(32'h0,   4'hF, 32'hDEAD_0001, rd, cyc, nwr, nrd);
    chk("fl_prep0_cycles", cyc, 5);
    access(32'h7F0, 4'hF, 32'hBEEF_0127, rd, cyc, nwr, nrd);
    chk("fl_prep127_cycles", cyc, 5);
    do_flush(nwr, ndone);
    chk("flush_wr_acks", nwr, 8);
    chk("flush_done_pulses", ndone, 1);
    if (nwr == 8) begin
      chk("flush_wr0_addr", wr_q[0].addr, 32'h0);
      chk("flush_wr0_data", wr_q[0].data, 32'hDEAD_0001);
      chk("flush_wr4_addr", wr_q[4].addr, 32'h7F0);
      chk("flush_wr4_data", wr_q[4].data, 32'hBEEF_0127);
    end
    chk("flush_busy_after", 32'(busy), 0);
    access(32'h0, 4'h0, 32'h0, rd, cyc, nwr, nrd);
    chk("post_flush_rdata", rd, 32'hDEAD_0001);
    chk("post_flush_cycles", cyc, 5);
    chk("post_flush_wr_acks", nwr, 0);
    access(32'h7F0, 4'h0, 32'h0, rd, cyc, nwr, nrd);
    chk("post_flush127_cycles", cyc, 5);

    // Reset during a refill, after two words have been transferred.
    @(negedge clk);
    rd_q.delete();
    cpu_addr = 32'h500;
    cpu_we   = '0;
    cpu_req  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (rd_q.size() >= 2) break;
    end
    chk("rstmid_two_acks", rd_q.size(), 2);
    @(negedge clk);
    #1;
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid_mem_req", 32'(mem_req), 0);
    chk("rstmid_busy", 32'(busy), 0);
    access(32'h500, 4'h0, 32'h0, rd, cyc, nwr, nrd);
    chk("rstmid_refetch_rdata", rd, dflt(32'h500));
    chk("rstmid_refetch_cycles", cyc, 5);
    chk("rstmid_refetch_rd_acks", nrd, 4);
    if (nrd > 0) chk("rstmid_refetch_addr0", rd_q[0].addr, 32'h500);

    // Randomized run against the flat-memory / tag-directory model.
    do_reset();
    ref_m.delete();
    for (int i = 0; i < NL; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    idx_set = '{0, 1, 2, 127};
    stray   = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        int nd;
        nd = 0;
        for (int i = 0; i < NL; i++) if (mdirty[i]) nd++;
        do_flush(nwr, ndone);
        chk($sformatf("rnd%0d_flush_wr_acks", n), nwr, 4*nd);
        chk($sformatf("rnd%0d_flush_done", n), ndone, 1);
        for (int i = 0; i < NL; i++) begin
          mvalid[i] = 1'b0;
          mdirty[i] = 1'b0;
        end
      end else begin
        logic [31:0] a, wd, exp_rd, mask, tag;
        logic [3:0]  we;
        int          ix;
        bit          hit;
        tag = $urandom_range(0, 3);
        ix  = idx_set[$urandom_range(0, 3)];
        a   = (tag << 11) | (32'(ix) << 4) | (32'($urandom_range(0, 3)) << 2);
        we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        wd  = $urandom;
        hit = mvalid[ix] && (mtag[ix] == tag);
        exp_rd = ref_rd(a);
        access(a, we, wd, rd, cyc, nwr, nrd);
        if (we == 0) chk($sformatf("rnd%0d_rdata@%h", n, a), rd, exp_rd);
        chk($sformatf("rnd%0d_wr_acks", n), nwr, (!hit && mdirty[ix]) ? 4 : 0);
        chk($sformatf("rnd%0d_rd_acks", n), nrd, hit ? 0 : 4);
        chk($sformatf("rnd%0d_cycles", n), cyc, hit ? 0 : ((mdirty[ix] ? 8 : 4) + 1));
        if (we != 0) begin
          for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{we[b]}};
          ref_m[a] = (exp_rd & ~mask) | (wd & mask);
        end
        mdirty[ix] = (hit && mdirty[ix]) || (we != 0);
        mvalid[ix] = 1'b1;
        mtag[ix]   = tag;
      end
    end
    do_flush(nwr, ndone);
    chk("rnd_final_flush_done", ndone, 1);
    foreach (ref_m[k]) chk($sformatf("rnd_mem@%h", k), mem_rd(k), ref_m[k]);
    stray = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
